// File: rtl/prio_rr_arbiter.sv
// Three-tier arbiter: promoted (lowest index) > urgent (round-robin) > normal (round-robin).
// Define PRIO_RR_ARBITER_AGING_EN to promote normal requesters that keep losing decisions.
module prio_rr_arbiter #(
  parameter int N          = 8,
  parameter int STARVE_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         ready,
  input  logic [N-1:0]         ready_urgent,
  input  logic                 sel_ack,
  output logic [N-1:0]         sel,
  output logic [$clog2(N)-1:0] sel_idx,
  output logic                 sel_valid,
  output logic                 sel_valid_urgent
);

  localparam int IW = $clog2(N);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]    state;
  logic [IW-1:0] urg_ptr;
  logic [IW-1:0] nrm_ptr;
  logic          grant_promoted;

  logic [N-1:0]  urgent_req;
  logic [N-1:0]  normal_req;
  logic [N-1:0]  promoted_req;

  logic          pick_valid;
  logic          pick_urgent;
  logic          pick_promoted;
  logic [IW-1:0] pick_idx;
  logic [N-1:0]  pick_onehot;

  function automatic logic [IW-1:0] rr_first(input logic [N-1:0] req,
                                             input logic [IW-1:0] ptr);
    logic [IW-1:0] idx;
    logic          found;
    int            p;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      p = int'(ptr) + i;
      if (p >= N) p = p - N;
      if (!found && req[p]) begin
        found = 1'b1;
        idx   = IW'(p);
      end
    end
    return idx;
  endfunction

  function automatic logic [IW-1:0] lowest_first(input logic [N-1:0] req);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
    return idx;
  endfunction

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] k);
    return (int'(k) == N - 1) ? '0 : k + IW'(1);
  endfunction

  // A requester raising both classes competes as urgent only.
  assign urgent_req = ready_urgent;
  assign normal_req = ready & ~ready_urgent;

`ifdef PRIO_RR_ARBITER_AGING_EN
  localparam int            CW      = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] AGE_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] age_cnt [N];

  always_comb begin
    promoted_req = '0;
    for (int i = 0; i < N; i++) begin
      promoted_req[i] = normal_req[i] && (age_cnt[i] == AGE_MAX);
    end
  end

  // Counters only move when a decision is actually taken, not while a grant is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) age_cnt[i] <= '0;
    end else if (state == IDLE && pick_valid) begin
      for (int i = 0; i < N; i++) begin
        if (!ready[i] || (pick_idx == IW'(i))) begin
          age_cnt[i] <= '0;
        end else if (!ready_urgent[i] && (age_cnt[i] != AGE_MAX)) begin
          age_cnt[i] <= age_cnt[i] + CW'(1);
        end
      end
    end
  end
`else
  assign promoted_req = '0;
`endif

  always_comb begin
    pick_valid    = |(urgent_req | normal_req);
    pick_urgent   = 1'b0;
    pick_promoted = 1'b0;
    pick_idx      = '0;
    if (|promoted_req) begin
      pick_idx      = lowest_first(promoted_req);
      pick_urgent   = 1'b1;
      pick_promoted = 1'b1;
    end else if (|urgent_req) begin
      pick_idx    = rr_first(urgent_req, urg_ptr);
      pick_urgent = 1'b1;
    end else if (|normal_req) begin
      pick_idx = rr_first(normal_req, nrm_ptr);
    end
    pick_onehot           = '0;
    pick_onehot[pick_idx] = 1'b1;
  end

  assign sel_valid = (state == GRANT);

  // Grant outputs are frozen for the whole GRANT state; pointers advance only on acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      sel              <= '0;
      sel_idx          <= '0;
      sel_valid_urgent <= 1'b0;
      grant_promoted   <= 1'b0;
      urg_ptr          <= '0;
      nrm_ptr          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state            <= GRANT;
            sel              <= pick_onehot;
            sel_idx          <= pick_idx;
            sel_valid_urgent <= pick_urgent;
            grant_promoted   <= pick_promoted;
          end
        end
        GRANT: begin
          if (sel_ack) begin
            state            <= IDLE;
            sel              <= '0;
            sel_idx          <= '0;
            sel_valid_urgent <= 1'b0;
            grant_promoted   <= 1'b0;
            if (!grant_promoted) begin
              if (sel_valid_urgent) urg_ptr <= next_ptr(sel_idx);
              else                  nrm_ptr <= next_ptr(sel_idx);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
